// File: rtl/echo_pkg.sv
// Shared mode encodings, FSM states and sample helpers for the multi-tap echo stage.
package echo_pkg;

  localparam logic [1:0] MODE_BYPASS = 2'b00;
  localparam logic [1:0] MODE_FIR    = 2'b01;
  localparam logic [1:0] MODE_FB     = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_DRAIN,
    ST_SAT,
    ST_WR
  } state_t;

  // Offset-binary midpoint for a w-bit sample.
  function automatic int midpoint(input int w);
    return 1 << (w - 1);
  endfunction

  // Clamp a signed value into the w-bit two's complement range.
  function automatic int clamp_s(input int v, input int w);
    int hi;
    int lo;
    hi = midpoint(w) - 1;
    lo = -midpoint(w);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/echo_ram.sv
// Single-port sample buffer, 2^ADDR_W x DATA_W, registered read (1 cycle).
// No reset on the array so it maps onto block RAM; callers gate stale contents.
module echo_ram #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/echo_multitap.sv
// Multi-tap echo: live sample plus N_TAPS delayed, attenuated buffer taps (FIR or feedback), saturated.
// Latency N_TAPS+3 cycles strobe to out_valid; no backpressure, strobes while busy are dropped and set overrun.
module echo_multitap
  import echo_pkg::*;
#(
  parameter int DATA_W     = 10,
  parameter int ADDR_W     = 13,
  parameter int N_TAPS     = 3,
  parameter int GAIN_SHIFT = 1
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] delay,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int KW    = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam int OFF_W = ADDR_W + $clog2(N_TAPS) + 1;
  localparam int ACC_W = DATA_W + $clog2(N_TAPS + 1) + 1;

  localparam logic [DATA_W-1:0] MID    = DATA_W'(midpoint(DATA_W));
  localparam logic [OFF_W-1:0]  DEPTH  = OFF_W'(1 << ADDR_W);
  localparam logic [ADDR_W:0]   FULL   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [KW-1:0]     K_LAST = KW'(N_TAPS - 1);

  state_t state, state_nxt;

  logic [DATA_W-1:0]        x_in, ram_rdata, ram_wdata;
  logic signed [DATA_W-1:0] x_q, y_q, y_c;
  logic [ADDR_W-1:0]        delay_q, wptr, rd_addr, ram_addr;
  logic [1:0]               mode_q;
  logic signed [ACC_W-1:0]  acc, tap_term;
  logic [OFF_W-1:0]         off;
  logic [KW-1:0]            k, tap_k;
  logic [ADDR_W:0]          fill;
  logic                     tap_vld, tap_ok, accept, ram_we;

  always_ff @(posedge sysclk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (data_valid) begin
          accept    = 1'b1;
          state_nxt = ST_RD;
        end
      end
      ST_RD:    if (k == K_LAST) state_nxt = ST_DRAIN;
      ST_DRAIN: state_nxt = ST_SAT;
      ST_SAT:   state_nxt = ST_WR;
      ST_WR:    state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // A tap is only usable once that many samples exist and it still lies inside the buffer.
  assign x_in      = data_in ^ MID;
  assign rd_addr   = wptr - off[ADDR_W-1:0];
  assign tap_ok    = (delay_q != '0) && (off <= OFF_W'(fill)) && (off < DEPTH);
  assign ram_we    = (state == ST_WR);
  assign ram_addr  = ram_we ? wptr : rd_addr;
  assign ram_wdata = (mode_q == MODE_FB) ? y_q : x_q;

  always_comb begin
    tap_term = {{(ACC_W - DATA_W){ram_rdata[DATA_W-1]}}, ram_rdata};
    tap_term = tap_term >>> (GAIN_SHIFT * (int'(tap_k) + 1));
  end

  assign y_c = DATA_W'(clamp_s(int'(acc), DATA_W));

  always_ff @(posedge sysclk) begin
    if (reset) begin
      data_out  <= MID;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      wptr      <= '0;
      fill      <= '0;
      tap_vld   <= 1'b0;
      tap_k     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      delay_q   <= '0;
      mode_q    <= MODE_BYPASS;
      acc       <= '0;
      off       <= '0;
      k         <= '0;
    end else begin
      out_valid <= (state == ST_SAT);
      tap_vld   <= (state == ST_RD) && tap_ok && (mode_q != MODE_BYPASS);
      tap_k     <= k;
      if (data_valid && busy) overrun <= 1'b1;

      if (accept) begin
        x_q     <= x_in;
        delay_q <= delay;
        mode_q  <= (mode == MODE_FIR || mode == MODE_FB) ? mode : MODE_BYPASS;
        acc     <= {{(ACC_W - DATA_W){x_in[DATA_W-1]}}, x_in};
        off     <= OFF_W'(delay);
        k       <= '0;
      end

      // Running sum replaces delay*(k+1).
      if (state == ST_RD) begin
        off <= off + OFF_W'(delay_q);
        k   <= k + 1'b1;
      end

      if (tap_vld) acc <= acc + tap_term;

      if (state == ST_SAT) begin
        y_q      <= y_c;
        data_out <= y_c ^ MID;
      end

      if (state == ST_WR) begin
        wptr <= wptr + 1'b1;
        if (fill != FULL) fill <= fill + 1'b1;
      end
    end
  end

  echo_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (sysclk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_echo_multitap.sv
// Directed bench for echo_multitap: vector table for streams plus hand sequences for timing and overrun.
module tb_echo_multitap;

  logic        sysclk = 1'b0;
  logic        reset = 1'b1;
  logic        data_valid = 1'b0;
  logic [9:0]  data_in = '0;
  logic [12:0] delay = '0;
  logic [1:0]  mode = '0;
  logic [9:0]  data_out;
  logic        out_valid, busy, overrun;

  int errors = 0;
  int checks = 0;

  always #10 sysclk = ~sysclk;

  echo_multitap #(
    .DATA_W(10), .ADDR_W(13), .N_TAPS(3), .GAIN_SHIFT(1)
  ) dut (
    .sysclk(sysclk), .reset(reset), .data_valid(data_valid), .data_in(data_in),
    .delay(delay), .mode(mode), .data_out(data_out), .out_valid(out_valid),
    .busy(busy), .overrun(overrun)
  );

  typedef struct {
    bit         rst;
    logic [1:0] mode;
    logic [12:0] dly;
    logic [9:0] din;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   xs[8200];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic addv(input bit r, input logic [1:0] m, input int d, input int din, input int exp);
    vec_t v;
    v.rst = r; v.mode = m; v.dly = 13'(d); v.din = 10'(din); v.exp = 10'(exp);
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge sysclk);
    reset = 1'b1;
    data_valid = 1'b0;
    repeat (2) @(negedge sysclk);
    reset = 1'b0;
  endtask

  // Called at a negedge; returns at the following negedge with the strobe removed.
  task automatic pulse(input logic [9:0] din);
    data_in = din;
    data_valid = 1'b1;
    @(negedge sysclk);
    data_valid = 1'b0;
  endtask

  task automatic send(input logic [1:0] m, input logic [12:0] d, input logic [9:0] din,
                      output logic [9:0] dout);
    bit got;
    got = 1'b0;
    dout = '0;
    @(negedge sysclk);
    mode = m;
    delay = d;
    pulse(din);
    for (int n = 0; n < 20 && !got; n++) begin
      if (out_valid) begin
        got = 1'b1;
        dout = data_out;
      end else begin
        @(negedge sysclk);
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: no out_valid within 20 cycles for din 0x%0h", din);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at 5 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] dout;
    int busy_n, ov_n, ov_at, n, e, v;

    // FIR, delay 4, constant 0x300: taps come alive at samples 5, 9, 13.
    for (int i = 0; i < 13; i++)
      addv(i == 0, 2'b01, 4, 'h300, (i < 4) ? 'h300 : (i < 8) ? 'h380 : (i < 12) ? 'h3C0 : 'h3E0);
    // FIR, delay 1: positive clamp, then the transition into negative clamp.
    for (int i = 0; i < 10; i++) addv(i == 0, 2'b01, 1, 'h3FF, 'h3FF);
    addv(0, 2'b01, 1, 'h000, 'h1BD);
    for (int i = 0; i < 3; i++) addv(0, 2'b01, 1, 'h000, 'h000);
    // Feedback, delay 2: impulse recirculates through stored outputs.
    addv(1, 2'b10, 2, 'h300, 'h300);
    addv(0, 2'b10, 2, 'h200, 'h200);
    addv(0, 2'b10, 2, 'h200, 'h280);
    addv(0, 2'b10, 2, 'h200, 'h200);
    addv(0, 2'b10, 2, 'h200, 'h280);
    addv(0, 2'b10, 2, 'h200, 'h200);
    addv(0, 2'b10, 2, 'h200, 'h280);
    addv(0, 2'b10, 2, 'h200, 'h200);
    addv(0, 2'b10, 2, 'h200, 'h270);
    // Bypass modes still fill the buffer; a later FIR sample sees them.
    addv(1, 2'b11, 1, 'h300, 'h300);
    addv(0, 2'b11, 1, 'h300, 'h300);
    addv(0, 2'b00, 1, 'h300, 'h300);
    addv(0, 2'b01, 1, 'h300, 'h3E0);

    do_reset();
    check("rst_data_out", data_out, 'h200);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      send(vecs[i].mode, vecs[i].dly, vecs[i].din, dout);
      check($sformatf("vec%0d", i), dout, vecs[i].exp);
    end

    // Bypass latency: strobe in cycle 0, out_valid only in cycle 6, busy cycles 1..6.
    do_reset();
    mode = 2'b00;
    delay = 13'd3;
    pulse(10'h155);
    busy_n = 0; ov_n = 0; ov_at = -1; dout = '0;
    for (int c = 1; c <= 9; c++) begin
      if (busy) busy_n++;
      if (out_valid) begin ov_n++; ov_at = c; dout = data_out; end
      if (c == 5) check("lat_held_before", data_out, 'h200);
      @(negedge sysclk);
    end
    check("lat_busy_cycles", busy_n, 6);
    check("lat_out_valid_cycles", ov_n, 1);
    check("lat_out_valid_at", ov_at, 6);
    check("lat_data_out", dout, 'h155);

    // Two strobes 2 cycles apart: the second is dropped.
    do_reset();
    mode = 2'b01;
    delay = 13'd4;
    check("ovr_before", overrun, 0);
    pulse(10'h300);
    @(negedge sysclk);
    pulse(10'h100);
    ov_n = 0;
    for (int c = 0; c < 16; c++) begin
      if (out_valid) begin ov_n++; dout = data_out; end
      @(negedge sysclk);
    end
    check("ovr_out_count", ov_n, 1);
    check("ovr_first_out", dout, 'h300);
    check("ovr_flag", overrun, 1);
    // Only the first sample was buffered: tap0 sees 0x300, tap1 not yet valid.
    send(2'b01, 13'd1, 10'h300, dout);
    check("ovr_next_out", dout, 'h380);
    check("ovr_sticky", overrun, 1);

    // Strobe landing in the write-back cycle is also dropped.
    do_reset();
    check("ovr_cleared", overrun, 0);
    mode = 2'b00;
    pulse(10'h123);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge sysclk);
      n++;
    end
    check("wr_out_valid_seen", out_valid, 1);
    pulse(10'h0AA);
    ov_n = 0;
    for (int c = 0; c < 12; c++) begin
      if (out_valid) ov_n++;
      @(negedge sysclk);
    end
    check("wr_drop_count", ov_n, 0);
    check("wr_overrun", overrun, 1);
    check("wr_data_out", data_out, 'h123);

    // Reset in the middle of a sample aborts it.
    pulse(10'h3FF);
    @(negedge sysclk);
    reset = 1'b1;
    @(negedge sysclk);
    reset = 1'b0;
    ov_n = 0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) ov_n++;
      @(negedge sysclk);
    end
    check("abort_out_count", ov_n, 0);
    check("abort_busy", busy, 0);
    check("abort_data_out", data_out, 'h200);
    check("abort_overrun", overrun, 0);

    // Delay 0x1000 across the pointer wrap: only tap0 ever contributes.
    do_reset();
    for (int i = 0; i < 8200; i++) begin
      v = (i * 37 + 11) & 'h3FF;
      xs[i] = (v ^ 'h200) >= 512 ? (v ^ 'h200) - 1024 : (v ^ 'h200);
      e = xs[i] + ((i >= 4096) ? (xs[i - 4096] >>> 1) : 0);
      if (e > 511) e = 511;
      if (e < -512) e = -512;
      send(2'b01, 13'h1000, 10'(v), dout);
      check($sformatf("wrap%0d", i), dout, (e + 512) & 'h3FF);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
